fixed_point_argmax: RTL and testbench

// - Streaming signed fixed-point max/argmax reducer. Parametrised sequential successor of the
//   two-operand fixed-point comparator.
// - Consumes a packet of samples over a valid/ready stream. Reports the largest value and its

---
 rtl/fixed_point_argmax_if.sv | 26 ++
 rtl/fixed_point_argmax.sv | 110 +++++++++++
 tb/tb_fixed_point_argmax.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/fixed_point_argmax_if.sv
// Sample stream in, max/argmax result out. The upstream/downstream side uses
// the master modport and the reducer uses the slave modport.
interface fixed_point_argmax_if #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned IDX_WIDTH = 4
);
   logic [WIDTH-1:0]     value;
   logic                 value_valid;
   logic                 value_last;
   logic                 value_ready;
   logic [WIDTH-1:0]     max_value;
   logic [IDX_WIDTH-1:0] max_index;
   logic                 overflow;
   logic                 result_valid;
   logic                 result_ready;

   modport master (
      output value, value_valid, value_last, result_ready,
      input  value_ready, max_value, max_index, overflow, result_valid
   );

   modport slave (
      input  value, value_valid, value_last, result_ready,
      output value_ready, max_value, max_index, overflow, result_valid
   );
endinterface

// File: rtl/fixed_point_argmax.sv
// Streaming signed fixed-point max/argmax reducer.
// Accepts one packet of samples, then holds the maximum and its zero-based index
// until the result is taken. Packets longer than MAX_LEN are cut at MAX_LEN with
// the overflow flag set.
// Build option: FIXED_POINT_ARGMAX_TIE_LAST_EN makes ties move the index to the
// latest equal sample (default keeps the earliest).
module fixed_point_argmax #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned FRAC_BITS = 3,
   parameter int unsigned MAX_LEN   = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   fixed_point_argmax_if.slave  bus_io
);
   localparam int unsigned IDX_WIDTH = $clog2(MAX_LEN);

   // Both operands share one format, so the fractional point never matters.
   if (FRAC_BITS >= WIDTH || MAX_LEN < 2) begin : g_bad_params
      $error("fixed_point_argmax: need FRAC_BITS < WIDTH and MAX_LEN >= 2");
   end

   typedef enum logic [1:0] {StIdle, StAccum, StResult} state_e;

   state_e               state_q, state_d;
   logic [WIDTH-1:0]     max_q, max_d;
   logic [IDX_WIDTH-1:0] idx_q, idx_d;
   logic [IDX_WIDTH-1:0] cnt_q, cnt_d;
   logic                 ovf_q, ovf_d;
   logic                 beat;
   logic                 take;

   assign beat = bus_io.value_valid & bus_io.value_ready;

   // New-maximum decision; masked by beat so an idle VALUE_IN never matters.
`ifdef FIXED_POINT_ARGMAX_TIE_LAST_EN
   assign take = beat & ($signed(bus_io.value) >= $signed(max_q));
`else
   assign take = beat & ($signed(bus_io.value) > $signed(max_q));
`endif

   // State and result registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         max_q   <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         max_q   <= max_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

   // Next-state: load on first sample, compare on later ones, hold in result.
   always_comb begin
      state_d = state_q;
      max_d   = max_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         StIdle: begin
            if (beat) begin
               max_d   = bus_io.value;
               idx_d   = '0;
               cnt_d   = IDX_WIDTH'(1);
               ovf_d   = 1'b0;
               state_d = bus_io.value_last ? StResult : StAccum;
            end
         end
         StAccum: begin
            if (beat) begin
               if (take) begin
                  max_d = bus_io.value;
                  idx_d = cnt_q;
               end
               cnt_d = cnt_q + IDX_WIDTH'(1);
               if (bus_io.value_last) begin
                  state_d = StResult;
               end else if (cnt_q == IDX_WIDTH'(MAX_LEN - 1)) begin
                  // Buffer full: close the packet; the rest starts a new one.
                  state_d = StResult;
                  ovf_d   = 1'b1;
               end
            end
         end
         StResult: begin
            if (bus_io.result_ready) begin
               state_d = StIdle;
               ovf_d   = 1'b0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs: ready is forced low while reset is held.
   always_comb begin
      bus_io.value_ready  = (state_q != StResult) & ~rst_i;
      bus_io.result_valid = (state_q == StResult);
      bus_io.max_value    = max_q;
      bus_io.max_index    = idx_q;
      bus_io.overflow     = ovf_q;
   end
endmodule

// File: tb/tb_fixed_point_argmax.sv
// Directed bench for fixed_point_argmax (WIDTH=8, FRAC_BITS=3, MAX_LEN=4).
module tb_fixed_point_argmax;
   localparam int unsigned Width   = 8;
   localparam int unsigned MaxLen  = 4;
   localparam int unsigned IdxW    = $clog2(MaxLen);

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   fixed_point_argmax_if #(.WIDTH(Width), .IDX_WIDTH(IdxW)) bus ();

   fixed_point_argmax #(
      .WIDTH    (Width),
      .FRAC_BITS(3),
      .MAX_LEN  (MaxLen)
   ) u_dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus_io(bus.slave)
   );

   always #5 clk_i = ~clk_i;

`ifdef FIXED_POINT_ARGMAX_TIE_LAST_EN
   localparam int TieIdx = 1;
`else
   localparam int TieIdx = 0;
`endif

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Offers one sample from the next falling edge; returns just after it is taken.
   task automatic send(input logic [7:0] v, input logic last, input int gap);
      int n;
      for (int i = 0; i < gap; i++) @(negedge clk_i);
      @(negedge clk_i);
      bus.value       = v;
      bus.value_last  = last;
      bus.value_valid = 1'b1;
      n = 0;
      while (!bus.value_ready && n < 20) begin
         @(negedge clk_i);
         n++;
      end
      if (n >= 20) check("send_timeout", 32'(bus.value_ready), 32'd1);
      @(posedge clk_i);
      #1;
      bus.value_valid = 1'b0;
      bus.value_last  = 1'b0;
      bus.value       = 'x;
   endtask

   // Waits for a result, checks it, then completes the handshake.
   task automatic get_result(input string tag, input logic [7:0] m, input int idx,
                             input logic ovf);
      int n = 0;
      while (!bus.result_valid && n < 20) begin
         @(negedge clk_i);
         n++;
      end
      check({tag, "_valid"}, 32'(bus.result_valid), 32'd1);
      check({tag, "_max"}, 32'(bus.max_value), 32'(m));
      check({tag, "_idx"}, 32'(bus.max_index), 32'(idx));
      check({tag, "_ovf"}, 32'(bus.overflow), 32'(ovf));
      @(negedge clk_i);
      bus.result_ready = 1'b1;
      @(posedge clk_i);
      #1;
      bus.result_ready = 1'b0;
      check({tag, "_done"}, 32'(bus.result_valid), 32'd0);
      check({tag, "_rdy_back"}, 32'(bus.value_ready), 32'd1);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_ready"}, 32'(bus.value_ready), 32'd0);
      check({tag, "_rvalid"}, 32'(bus.result_valid), 32'd0);
      check({tag, "_max"}, 32'(bus.max_value), 32'd0);
      check({tag, "_idx"}, 32'(bus.max_index), 32'd0);
      check({tag, "_ovf"}, 32'(bus.overflow), 32'd0);
   endtask

   initial begin
      bus.value        = 'x;
      bus.value_valid  = 1'b0;
      bus.value_last   = 1'b0;
      bus.result_ready = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      check_zero("reset");
      @(negedge clk_i);
      rst_i = 1'b0;
      @(negedge clk_i);
      check("idle_ready", 32'(bus.value_ready), 32'd1);

      // Test 1: basic packet, result visible right after the last beat.
      send(8'h08, 1'b0, 0);
      send(8'hF0, 1'b0, 0);
      send(8'h14, 1'b0, 0);
      send(8'h0C, 1'b1, 0);
      check("t1_latency", 32'(bus.result_valid), 32'd1);
      get_result("t1", 8'h14, 2, 1'b0);

      // Test 2: all negative, then a single-sample packet at the positive extreme.
      send(8'h80, 1'b0, 0);
      send(8'hF8, 1'b0, 0);
      send(8'hFC, 1'b1, 0);
      get_result("t2a", 8'hFC, 2, 1'b0);
      send(8'h7F, 1'b1, 0);
      get_result("t2b", 8'h7F, 0, 1'b0);

      // Test 3: ties.
      send(8'h10, 1'b0, 0);
      send(8'h10, 1'b0, 0);
      send(8'h08, 1'b1, 0);
      get_result("t3", 8'h10, TieIdx, 1'b0);

      // Test 4: truncation at MAX_LEN=4; fifth sample becomes its own packet.
      send(8'h01, 1'b0, 0);
      send(8'h02, 1'b0, 0);
      send(8'h05, 1'b0, 0);
      send(8'h03, 1'b0, 0);
      get_result("t4a", 8'h05, 2, 1'b1);
      send(8'h04, 1'b1, 0);
      get_result("t4b", 8'h04, 0, 1'b0);

      // Test 5: result backpressure with input gaps; valid offered while blocked.
      send(8'h08, 1'b0, $urandom_range(0, 3));
      send(8'hF0, 1'b0, $urandom_range(0, 3));
      send(8'h14, 1'b0, $urandom_range(0, 3));
      send(8'h0C, 1'b1, $urandom_range(0, 3));
      bus.value       = 8'h7F;
      bus.value_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_i);
         check("t5_blocked", 32'(bus.value_ready), 32'd0);
         check("t5_stable_max", 32'(bus.max_value), 32'h14);
         check("t5_stable_idx", 32'(bus.max_index), 32'd2);
      end
      bus.value_valid = 1'b0;
      get_result("t5", 8'h14, 2, 1'b0);

      // Test 6: reset in the middle of a packet discards it.
      send(8'h7F, 1'b0, 0);
      send(8'h00, 1'b0, 0);
      @(negedge clk_i);
      rst_i = 1'b1;
      @(posedge clk_i);
      #1;
      check_zero("t6_rst");
      @(negedge clk_i);
      rst_i = 1'b0;
      send(8'h02, 1'b0, 0);
      send(8'h01, 1'b1, 0);
      get_result("t6", 8'h02, 0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end
endmodule
